rr_mux_select: RTL and testbench

Four-channel round-robin select sequencer sitting directly upstream of the 4-to-1 data mux. It arbitrates between four request lines and drives the mux select pair (s0, s1) plus a one-hot grant. The select is held stable for the whole ownership interval so the mux output never glitches between sources. Ownership can be bounded by a programmable hold limit.

---
 rtl/rr_mux_select_pkg.sv | 20 ++
 rtl/rr_mux_select_pick4.sv | 28 ++
 rtl/rr_mux_select.sv | 84 ++++++++
 tb/tb_rr_mux_select.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rr_mux_select_pkg.sv
// Shared definitions for the four-channel round-robin mux select sequencer.
// State encoding, channel count and select width live here so every stage agrees.
package rr_mux_select_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    function automatic logic [NCH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_select_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 3 -> 0.
// Kept free of state so any future four-way round-robin stage can reuse it.
module rr_pick4
    import rr_mux_select_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             found
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset down so the nearest request to ptr is written last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_select.sv
// Round-robin select sequencer in front of a 4:1 data mux; select is held for the whole
// ownership interval and only changes on a new grant. MAX_HOLD must be < 2**CNT_W.
module rr_mux_select
    import rr_mux_select_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           done,
    output logic           s0,
    output logic           s1,
    output logic [NCH-1:0] grant,
    output logic           busy
);

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] sel_q;
    logic [NCH-1:0]   grant_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [SEL_W-1:0] pick_d;
    logic             found_d;
    logic             hold_hit_d;
    logic             release_d;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick_d),
        .found (found_d)
    );

    // sel_q doubles as the owner index while in ST_OWN.
    always_comb begin
        hold_hit_d = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));
        release_d  = done || !req[sel_q] || hold_hit_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        state_q <= ST_OWN;
                        sel_q   <= pick_d;
                        grant_q <= sel_to_onehot(pick_d);
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_OWN: begin
                    if (release_d) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= sel_q + SEL_W'(1);
                    end else if (cnt_q != '1) begin
                        // Saturate rather than wrap when the hold limit is disabled.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s0    = sel_q[1];
    assign s1    = sel_q[0];
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_rr_mux_select.sv
// Scoreboard bench for rr_mux_select: a cycle model of the arbitration rules predicts
// each post-edge output set; a monitor compares those against the DUT one edge at a time.
module tb_rr_mux_select;

    localparam int CNT_W    = 4;
    localparam int MAX_HOLD = 3;

    typedef struct packed {
        logic       busy;
        logic [3:0] grant;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       s0, s1, busy;
    logic [3:0] grant;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_sel   = 0;

    rr_mux_select #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .done  (done),
        .s0    (s0),
        .s1    (s1),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and predict the outputs seen after the next rising edge.
    task automatic step(input logic r_n, input logic [3:0] rq, input logic dn);
        exp_t e;
        @(negedge clk);
        rst_n = r_n;
        req   = rq;
        done  = dn;
        if (!r_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && rq[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_held  = 1;
                end
            end
        end else if (dn || !rq[m_owner] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_held = m_held + 1;
        end
        e.busy  = (m_owner >= 0);
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.sel   = 2'(m_sel);
        exp_q.push_back(e);
    endtask

    // Monitor: every edge where a prediction is pending, compare the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (busy !== e.busy || grant !== e.grant || {s0, s1} !== e.sel) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got busy=%b grant=%b sel=%b%b, expected busy=%b grant=%b sel=%b",
                             $time, busy, grant, s0, s1, e.busy, e.grant, e.sel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rq;
        logic       dn;

        // Reset then idle with no requests.
        step(1'b0, 4'b0000, 1'b0);
        repeat (5) step(1'b1, 4'b0000, 1'b0);

        // All requesting, done pulsed on the first busy cycle: 0,1,2,3,0 with idle gaps.
        for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, (m_owner >= 0));
        step(1'b1, 4'b0000, 1'b0);

        // ch2 owns, then drops its request while ch0 requests.
        step(1'b0, 4'b0000, 1'b0);
        repeat (3) step(1'b1, 4'b0100, 1'b0);
        repeat (4) step(1'b1, 4'b0001, 1'b0);

        // Forced release by the hold limit with a constant request.
        step(1'b0, 4'b0000, 1'b0);
        repeat (12) step(1'b1, 4'b0001, 1'b0);

        // Reset while ch3 owns, then ch1 and ch3 request.
        step(1'b0, 4'b0000, 1'b0);
        repeat (2) step(1'b1, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        repeat (6) step(1'b1, 4'b1010, 1'b0);

        // done while idle is ignored.
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        repeat (3) step(1'b1, 4'b0100, 1'b0);

        // Randomized traffic with sticky requests, sporadic done and rare resets.
        rq = 4'b0000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            dn = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 63) != 0), rq, dn);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
